// File: rtl/dekatron_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the dekatron seek controller.
package dekatron_pkg;

  localparam int DEK_WIDTH = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_SETTLE,
    S_DONE,
    S_ERR
  } seek_state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_t;

  // True when exactly one bit of the (zero-extended) cathode vector is set.
  function automatic logic onehot_valid(input logic [15:0] vec);
    logic [4:0] count;
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'b0000, vec[i]};
    end
    return (count == 5'd1);
  endfunction

endpackage

// File: rtl/dekatron_onehot_decode.sv
`timescale 1ns/1ps
// Converts the dekatron one-hot cathode readback into a binary position and
// flags readbacks that are blank or show more than one glowing cathode.
module dekatron_onehot_decode
  import dekatron_pkg::*;
#(
  parameter int WIDTH = DEK_WIDTH
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [3:0]       o_pos,
  output logic             o_invalid
);

  logic [15:0] w_vec16;

  assign w_vec16 = 16'(i_vec);

  // OR together the indices of all set bits; only meaningful when one-hot.
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        o_pos = o_pos | 4'(i);
      end
    end
  end

  assign o_invalid = !onehot_valid(w_vec16);

endmodule

// File: rtl/dekatron_seek.sv
`timescale 1ns/1ps
// Seek controller for a dekatron counting tube: steps the glow one cathode at
// a time (shortest way round, ties go right) until it sits on the target,
// verifying every step against the cathode readback.
module dekatron_seek
  import dekatron_pkg::*;
#(
  parameter int WIDTH         = DEK_WIDTH,
  parameter int PULSE_CYCLES  = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             hsClk,
  input  logic             Rst_n,
  input  logic             Request,
  input  logic [3:0]       Target,
  input  logic [WIDTH-1:0] DekOut,
  output logic             PulseRight,
  output logic             PulseLeft,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  localparam logic [3:0] WIDTH4      = 4'(WIDTH);
  localparam logic [4:0] WIDTH5      = 5'(WIDTH);
  localparam logic [4:0] HALF5       = 5'(WIDTH / 2);
  localparam logic [3:0] LAST_POS    = 4'(WIDTH - 1);
  localparam logic [3:0] MAX_STEPS   = 4'(WIDTH / 2);
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  seek_state_t      r_state, w_nextState;
  dir_t             r_dir, w_nextDir;
  logic [3:0]       r_target, w_nextTarget;
  logic [3:0]       r_prevPos, w_nextPrevPos;
  logic [3:0]       r_stepCount, w_nextStepCount;
  logic [7:0]       r_timer, w_nextTimer;
  logic             r_pulseRight, w_nextPulseRight;
  logic             r_pulseLeft, w_nextPulseLeft;
  logic             r_busy, w_nextBusy;
  logic             r_done, w_nextDone;
  logic             r_error, w_nextError;

  logic [3:0]       w_pos;
  logic             w_dekInvalid;
  logic             w_targetBad;
  logic [3:0]       w_diff;
  logic             w_goRight;
  logic [3:0]       w_expPos;
  logic [WIDTH-1:0] w_expOnehot;
  logic             w_settleMatch;

  dekatron_onehot_decode #(
    .WIDTH(WIDTH)
  ) u_decode (
    .i_vec    (DekOut),
    .o_pos    (w_pos),
    .o_invalid(w_dekInvalid)
  );

  // Distance to target measured rightwards, wrapped into 0..WIDTH-1 using
  // 4-bit arithmetic; adding WIDTH before subtracting keeps it non-negative.
  assign w_targetBad = ({1'b0, r_target} >= WIDTH5);
  assign w_diff      = (r_target >= w_pos) ? (r_target - w_pos)
                                           : (r_target + WIDTH4 - w_pos);
  assign w_goRight   = ({1'b0, w_diff} <= HALF5);

  // Where the glow should have landed after the last pulse.
  assign w_expPos = (r_dir == DIR_RIGHT)
                  ? ((r_prevPos == LAST_POS) ? 4'd0 : (r_prevPos + 4'd1))
                  : ((r_prevPos == 4'd0) ? LAST_POS : (r_prevPos - 4'd1));
  assign w_expOnehot   = {{(WIDTH-1){1'b0}}, 1'b1} << w_expPos;
  assign w_settleMatch = (DekOut == w_expOnehot);

  // State register plus all registered outputs; reset drops pulses at once.
  always_ff @(posedge hsClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_dir        <= DIR_RIGHT;
      r_target     <= '0;
      r_prevPos    <= '0;
      r_stepCount  <= '0;
      r_timer      <= '0;
      r_pulseRight <= 1'b0;
      r_pulseLeft  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_dir        <= w_nextDir;
      r_target     <= w_nextTarget;
      r_prevPos    <= w_nextPrevPos;
      r_stepCount  <= w_nextStepCount;
      r_timer      <= w_nextTimer;
      r_pulseRight <= w_nextPulseRight;
      r_pulseLeft  <= w_nextPulseLeft;
      r_busy       <= w_nextBusy;
      r_done       <= w_nextDone;
      r_error      <= w_nextError;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that they
  // line up exactly with the state they belong to once registered.
  always_comb begin
    w_nextState     = r_state;
    w_nextDir       = r_dir;
    w_nextTarget    = r_target;
    w_nextPrevPos   = r_prevPos;
    w_nextStepCount = r_stepCount;
    w_nextTimer     = r_timer;
    w_nextError     = r_error;

    case (r_state)
      S_IDLE: begin
        if (Request) begin
          w_nextError     = 1'b0;
          w_nextTarget    = Target;
          w_nextStepCount = '0;
          w_nextState     = S_CHECK;
        end
      end

      S_CHECK: begin
        if (w_targetBad || w_dekInvalid) begin
          w_nextState = S_ERR;
        end else if (w_diff == 4'd0) begin
          w_nextState = S_DONE;
        end else if (r_stepCount >= MAX_STEPS) begin
          w_nextState = S_ERR;
        end else begin
          w_nextDir       = w_goRight ? DIR_RIGHT : DIR_LEFT;
          w_nextPrevPos   = w_pos;
          w_nextStepCount = r_stepCount + 4'd1;
          w_nextTimer     = PULSE_LOAD;
          w_nextState     = S_PULSE;
        end
      end

      S_PULSE: begin
        if (r_timer == 8'd0) begin
          w_nextTimer = SETTLE_LOAD;
          w_nextState = S_SETTLE;
        end else begin
          w_nextTimer = r_timer - 8'd1;
        end
      end

      S_SETTLE: begin
        if (r_timer == 8'd0) begin
          w_nextState = w_settleMatch ? S_CHECK : S_ERR;
        end else begin
          w_nextTimer = r_timer - 8'd1;
        end
      end

      S_DONE: begin
        w_nextState = S_IDLE;
      end

      S_ERR: begin
        w_nextState = S_IDLE;
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    if (w_nextState == S_ERR) begin
      w_nextError = 1'b1;
    end

    w_nextPulseRight = (w_nextState == S_PULSE) && (w_nextDir == DIR_RIGHT);
    w_nextPulseLeft  = (w_nextState == S_PULSE) && (w_nextDir == DIR_LEFT);
    w_nextBusy       = (w_nextState == S_CHECK) || (w_nextState == S_PULSE) ||
                       (w_nextState == S_SETTLE);
    w_nextDone       = (w_nextState == S_DONE);
  end

  assign PulseRight = r_pulseRight;
  assign PulseLeft  = r_pulseLeft;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Error      = r_error;

endmodule

// File: tb/tb_dekatron_seek.sv
`timescale 1ns/1ps
// Self-checking bench for dekatron_seek: a tube model that steps on each
// guide pulse, a directed vector table, random seeks against a reference
// model, and a reset-during-pulse sequence.
module tb_dekatron_seek;

  localparam int STEP_CYCLES = 1 + 3 + 2;

  typedef struct {
    int         startPos;
    int         target;
    bit         useOv;
    logic [9:0] ovVal;
    bit         ignoreOne;
    bit         expErr;
    int         expSteps;
    bit         expRight;
    int         expEnd;
  } vec_t;

  logic       hsClk;
  logic       Rst_n;
  logic       Request;
  logic [3:0] Target;
  logic [9:0] DekOut;
  logic       PulseRight;
  logic       PulseLeft;
  logic       Busy;
  logic       Done;
  logic       Error;

  int checks   = 0;
  int failures = 0;

  int         dekBase    = 0;
  int         dekDelta   = 0;
  int         ignoreReq  = 0;
  int         ignoreDone = 0;
  bit         ovEn       = 0;
  logic [9:0] ovVal      = '0;
  int         curPos;

  vec_t vecs[14];

  dekatron_seek dut (
    .hsClk     (hsClk),
    .Rst_n     (Rst_n),
    .Request   (Request),
    .Target    (Target),
    .DekOut    (DekOut),
    .PulseRight(PulseRight),
    .PulseLeft (PulseLeft),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  initial hsClk = 1'b0;
  always #5 hsClk = ~hsClk;

  // Tube model: the glow jumps one cathode on each guide pulse, unless a
  // missed step has been requested.
  always @(posedge PulseRight or posedge PulseLeft) begin
    if (ignoreReq > ignoreDone) ignoreDone = ignoreDone + 1;
    else if (PulseRight) dekDelta = dekDelta + 1;
    else dekDelta = dekDelta - 1;
  end

  assign curPos = (((dekBase + dekDelta) % 10) + 10) % 10;
  assign DekOut = ovEn ? ovVal : (10'b1 << curPos);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference: shortest wrap-around path on a 10-position ring, ties right.
  function automatic void modelSeek(input int startPos, input int tgt,
                                    output bit expErr, output int expSteps,
                                    output bit expRight, output int expEnd);
    int diff;
    expErr = 0; expSteps = 0; expRight = 1; expEnd = 1;
    if (tgt >= 10) begin
      expErr = 1;
    end else begin
      diff = ((tgt - startPos) % 10 + 10) % 10;
      if (diff == 0) expSteps = 0;
      else if (diff <= 5) begin expSteps = diff; expRight = 1; end
      else begin expSteps = 10 - diff; expRight = 0; end
      expEnd = STEP_CYCLES * expSteps + 1;
    end
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int   c = 0;
    int   endCycle = -1;
    int   risesR = 0, risesL = 0, cycR = 0, cycL = 0, both = 0;
    bit   ended = 0, gotDone = 0, gotErr = 0;
    logic prevR = 0, prevL = 0;
    dekBase = v.startPos - dekDelta;
    ovEn    = v.useOv;
    ovVal   = v.ovVal;
    if (v.ignoreOne) ignoreReq = ignoreDone + 1;
    Request = 1'b1;
    Target  = 4'(v.target);
    @(posedge hsClk);
    while (!ended && c < 100) begin
      @(negedge hsClk);
      if (c == 0) begin
        Request = 1'b0;
        checkOutput({tag, ".busyInCheck"}, Busy, 1);
        checkOutput({tag, ".errClearedOnAccept"}, Error, 0);
      end
      if (PulseRight && PulseLeft) both++;
      if (PulseRight) cycR++;
      if (PulseLeft) cycL++;
      if (PulseRight && !prevR) risesR++;
      if (PulseLeft && !prevL) risesL++;
      prevR = PulseRight;
      prevL = PulseLeft;
      if (Done) begin gotDone = 1; ended = 1; endCycle = c; end
      else if (Error) begin gotErr = 1; ended = 1; endCycle = c; end
      c++;
    end
    checkOutput({tag, ".finishedInBudget"}, ended, 1);
    checkOutput({tag, ".gotError"}, gotErr, v.expErr);
    checkOutput({tag, ".gotDone"}, gotDone, !v.expErr);
    checkOutput({tag, ".endCycle"}, endCycle, v.expEnd);
    checkOutput({tag, ".pulseCount"}, v.expRight ? risesR : risesL, v.expSteps);
    checkOutput({tag, ".wrongDirPulses"}, v.expRight ? risesL : risesR, 0);
    checkOutput({tag, ".pulseCycles"}, v.expRight ? cycR : cycL, 3 * v.expSteps);
    checkOutput({tag, ".overlap"}, both, 0);
    if (!v.expErr) checkOutput({tag, ".finalPos"}, curPos, v.target);
    @(negedge hsClk);
    checkOutput({tag, ".doneOneCycle"}, Done, 0);
    checkOutput({tag, ".busyIdle"}, Busy, 0);
    checkOutput({tag, ".errorHeld"}, Error, v.expErr);
    ovEn = 0;
  endtask

  // Main sequence: reset, directed table, random seeks, reset mid-pulse.
  initial begin
    vec_t rv;
    int   doneSeen;
    vecs[0]  = '{0, 3,  0, 10'h000, 0, 0, 3, 1, 19};
    vecs[1]  = '{2, 8,  0, 10'h000, 0, 0, 4, 0, 25};
    vecs[2]  = '{4, 4,  0, 10'h000, 0, 0, 0, 1, 1};
    vecs[3]  = '{0, 12, 0, 10'h000, 0, 1, 0, 1, 1};
    vecs[4]  = '{5, 6,  0, 10'h000, 0, 0, 1, 1, 7};
    vecs[5]  = '{7, 2,  0, 10'h000, 0, 0, 5, 1, 31};
    vecs[6]  = '{9, 0,  0, 10'h000, 0, 0, 1, 1, 7};
    vecs[7]  = '{0, 9,  0, 10'h000, 0, 0, 1, 0, 7};
    vecs[8]  = '{3, 9,  0, 10'h000, 0, 0, 4, 0, 25};
    vecs[9]  = '{0, 3,  1, 10'h011, 0, 1, 0, 1, 1};
    vecs[10] = '{0, 3,  1, 10'h000, 0, 1, 0, 1, 1};
    vecs[11] = '{0, 10, 0, 10'h000, 0, 1, 0, 1, 1};
    vecs[12] = '{0, 3,  0, 10'h000, 1, 1, 1, 1, 6};
    vecs[13] = '{2, 4,  0, 10'h000, 0, 0, 2, 1, 13};

    Rst_n   = 1'b0;
    Request = 1'b0;
    Target  = 4'd0;
    repeat (2) @(negedge hsClk);
    checkOutput("reset.PulseRight", PulseRight, 0);
    checkOutput("reset.PulseLeft", PulseLeft, 0);
    checkOutput("reset.Busy", Busy, 0);
    checkOutput("reset.Done", Done, 0);
    checkOutput("reset.Error", Error, 0);
    Rst_n = 1'b1;
    @(negedge hsClk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      rv.startPos  = $urandom_range(0, 9);
      rv.target    = $urandom_range(0, 11);
      rv.useOv     = 0;
      rv.ovVal     = '0;
      rv.ignoreOne = 0;
      modelSeek(rv.startPos, rv.target, rv.expErr, rv.expSteps, rv.expRight, rv.expEnd);
      applyStimulus(rv, $sformatf("rand%0d", i));
    end

    dekBase = 0 - dekDelta;
    Request = 1'b1;
    Target  = 4'd3;
    @(posedge hsClk);
    @(negedge hsClk);
    Request = 1'b0;
    @(negedge hsClk);
    @(negedge hsClk);
    checkOutput("abort.pulseBeforeReset", PulseRight, 1);
    #1 Rst_n = 1'b0;
    #1;
    checkOutput("abort.pulseDropped", PulseRight, 0);
    checkOutput("abort.busyDropped", Busy, 0);
    checkOutput("abort.noDone", Done, 0);
    doneSeen = 0;
    repeat (3) begin
      @(negedge hsClk);
      if (Done || PulseRight || PulseLeft) doneSeen++;
    end
    checkOutput("abort.quietInReset", doneSeen, 0);
    Rst_n = 1'b1;
    rv = '{4, 4, 0, 10'h000, 0, 0, 0, 1, 1};
    applyStimulus(rv, "afterRelease.zero");
    rv = '{1, 4, 0, 10'h000, 0, 0, 3, 1, 19};
    applyStimulus(rv, "afterRelease.seek");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
